bloom_ctrl: RTL

Sequencer that owns the Bloom filter bit-vector and serialises query, insert and clear operations against it. For each request it builds the k-hash bit mask (gen_bloom) one hash per cycle, then performs the subset check or OR-in. Result is returned on a valid/ready response channel. It is the control wrapper placed between the packet/key source and the filter storage.

---
 rtl/bloom_ctrl_if.sv | 28 ++
 rtl/bloom_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bloom_ctrl_if.sv
// Request/response channel between a key source and bloom_ctrl.
//   req_valid/req_ready  : request handshake, req_op selects query/insert/clear
//   req_data             : key
//   resp_valid/resp_ready: response handshake
//   resp_match/resp_err  : membership result / reserved-opcode flag
// The master modport is the key source; the slave modport is the controller.
interface bloom_ctrl_if #(
    parameter int D_SIZE = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [D_SIZE-1:0] req_data;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_match;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_data, resp_ready,
        input  req_ready, resp_valid, resp_match, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, resp_ready,
        output req_ready, resp_valid, resp_match, resp_err
    );
endinterface

// File: rtl/bloom_ctrl.sv
// Bloom filter sequencer. Owns the filter bit-vector and serialises query,
// insert and clear requests against it. The k-hash mask for a key is built
// one hash per cycle, then checked against (and for inserts OR-ed into) the
// filter in a single apply cycle. Results are held on the response channel
// until the consumer takes them.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset (aborts any op, clears filter)
//   bus          : request/response channel (slave side)
//   gen_bloom    : mask of the current/last query or insert key
//   bloom_filter : filter contents
//   insert_count : completed inserts, saturating at all-ones
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request, req_ready high
// HASH   | adding one hash bit per cycle to gen_bloom (K_HASH cycles)
// APPLY  | subset check against the old filter; insert ORs the mask in
// CLEAR  | zero the filter
// RESP   | response valid, held until resp_ready
module bloom_ctrl #(
    parameter int D_SIZE  = 8,
    parameter int BL_SIZE = 32,
    parameter int K_HASH  = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bloom_ctrl_if.slave        bus,
    output logic [BL_SIZE-1:0] gen_bloom,
    output logic [BL_SIZE-1:0] bloom_filter,
    output logic [CNT_W-1:0]   insert_count
);

    localparam int LB = $clog2(BL_SIZE);
    localparam int HW = D_SIZE + 4;
    localparam int CW = $clog2(K_HASH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HASH,
        S_APPLY,
        S_CLEAR,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [D_SIZE-1:0]  key_q, key_d;
    logic               ins_q, ins_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BL_SIZE-1:0] gen_q, gen_d;
    logic [BL_SIZE-1:0] filt_q, filt_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;
    logic               match_q, match_d;
    logic               err_q, err_d;

    logic [HW-1:0]      key_ext;
    logic [LB-1:0]      h_idx;

    // h_i = ((key ^ (key >> i)) + 5*i) mod BL_SIZE, evaluated at D_SIZE+4 bits
    // and truncated to the bit index width.
    always_comb begin
        key_ext = HW'(key_q);
        h_idx   = LB'((key_ext ^ (key_ext >> cnt_q)) + (HW'(cnt_q) * HW'(5)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            ins_q   <= 1'b0;
            cnt_q   <= '0;
            gen_q   <= '0;
            filt_q  <= '0;
            icnt_q  <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ins_q   <= ins_d;
            cnt_q   <= cnt_d;
            gen_q   <= gen_d;
            filt_q  <= filt_d;
            icnt_q  <= icnt_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ins_d   = ins_q;
        cnt_d   = cnt_q;
        gen_d   = gen_q;
        filt_d  = filt_q;
        icnt_d  = icnt_q;
        match_d = match_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        2'b00, 2'b01: begin
                            key_d   = bus.req_data;
                            ins_d   = bus.req_op[0];
                            gen_d   = '0;
                            cnt_d   = '0;
                            state_d = S_HASH;
                        end
                        2'b10: state_d = S_CLEAR;
                        default: begin
                            err_d   = 1'b1;
                            match_d = 1'b0;
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_HASH: begin
                gen_d = gen_q | (BL_SIZE'(1) << h_idx);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K_HASH - 1)) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                // Subset test uses the filter as it was before this op.
                match_d = &(~gen_q | filt_q);
                if (ins_q) begin
                    filt_d = filt_q | gen_q;
                    if (icnt_q != '1) begin
                        icnt_d = icnt_q + CNT_W'(1);
                    end
                end
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_CLEAR: begin
                filt_d  = '0;
                match_d = 1'b0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_match = match_q;
    assign bus.resp_err   = err_q;
    assign gen_bloom      = gen_q;
    assign bloom_filter   = filt_q;
    assign insert_count   = icnt_q;

endmodule
